lsu_bus_if: RTL and testbench
=============================

Name: lsu_bus_if

Overview:
- Load/store unit between the memory-access stage and a word-wide external data bus with a valid/ready request handshake and a read-return strobe.
- Converts access requests (RV32 funct3 size encodings) into word-aligned bus transactions with byte strobes.
- Sign- or zero-extends load data.
- Raises `stall` to freeze the pipeline while a transaction is in flight, and flags misaligned, illegal-size and timed-out accesses.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT_R before abort; counter width = clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  access stage presents a load/store this cycle
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 size/sign field
req_addr  in  32  byte address
req_wdata  in  32  store data, low-aligned
stall  out  1  hold pipeline; request inputs must stay stable while high
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  32  extended load data, valid with rsp_valid (0 for stores)
fault  out  1  one-cycle pulse: access rejected or aborted
fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; 00 otherwise
bus_valid  out  1  request to bus
bus_ready  in  1  bus accepts request
bus_we  out  1  write request
bus_addr  out  32  {addr[31:2],2'b00}
bus_wstrb  out  4  byte enables (0000 on reads)
bus_wdata  out  32  lane-replicated store data
bus_rvalid  in  1  read data return strobe
bus_rdata  in  32  read data word

Behaviour:
- Reset: state=IDLE; timeout counter=0; latched request=0. Outputs: stall, rsp_valid, fault, bus_valid, bus_we=0; fault_cause=00; rsp_rdata, bus_addr, bus_wstrb, bus_wdata=0.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - req_valid with illegal funct3 or misalignment: fault=1 for one cycle with the matching cause (illegal has priority over misaligned). No bus access, no stall; stay IDLE.
  - req_valid and legal: stall=1 combinationally in this same cycle. Latch addr, we, funct3 and wdata; go to REQ.
- REQ:
  - bus_valid=1; bus_addr, bus_we, bus_wstrb and bus_wdata are held constant until bus_ready.
  - On bus_ready: a store goes to DONE; a load goes to WAIT_R.
  - bus_rvalid is never sampled in REQ.
- WAIT_R: on bus_rvalid, capture the extended data and go to DONE.
- DONE:
  - rsp_valid=1 and stall=0 for exactly one cycle, then IDLE.
  - req_valid in DONE is ignored; it is the same request, and the pipeline advances at this edge.
- Latency:
  - Store: 1 cycle IDLE→REQ, plus bus_ready wait, plus 1 cycle DONE.
  - Load: as for a store, plus the wait for bus_rvalid.
  - With ready and rvalid at the first opportunity, a load has rsp_valid 3 cycles after the request cycle.
- Strobes, stores (off = addr[1:0]):
  - SB: wstrb = 0001<<off; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<off; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; wdata as given.
- Load extraction:
  - Byte lane = rdata[8*off+:8]; halfword lane = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches TIMEOUT without completion: bus_valid drops, go to DONE with rsp_rdata=0 and fault=1/cause 11 in the DONE cycle. The pipeline is released.
- Stray strobes: bus_rvalid in IDLE, REQ or DONE is ignored.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. The outstanding bus request is abandoned; any later bus_rvalid is ignored.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, bus_ready on first REQ cycle → bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; stall high 2 cycles; rsp_valid in cycle 3.
- SB addr=0x203, wdata=0x000000A5 → bus_addr=0x200, wstrb=1000, wdata=0xA5A5A5A5; SH addr=0x202, wdata=0x1234 → wstrb=1100, wdata=0x12341234.
- LB addr=0x101 with bus_rdata=0x0000_80FF → rsp_rdata=0xFFFFFF80; LBU at same address and data → 0x00000080; LH addr=0x102 with bus_rdata=0x8001_0000 → 0xFFFF8001.
- LW addr=0x102 → fault=1, cause=01, no bus_valid, stall=0; funct3=011 load → cause=10.
- LW with bus_ready delayed 3 cycles and bus_rvalid 2 cycles after acceptance → bus_valid and bus_addr held stable; stall held for the full duration; one rsp_valid pulse.
- Load with bus_rvalid never asserted, TIMEOUT=4 → DONE after 4 cycles, fault cause 11, rsp_rdata=0. Also: rst asserted during WAIT_R → all outputs 0 immediately, and a later bus_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/lsu_bus_if_if.sv
// Word-wide external data bus between the load/store unit (master) and memory (slave).
// The request is a valid/ready handshake; read data returns later on a separate strobe.
interface lsu_bus_if_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_if.sv
// Load/store unit: turns RV32 load/store requests into word-aligned bus transactions,
// extends load data, stalls the pipeline while busy and flags bad or timed-out accesses.
module lsu_bus_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    lsu_bus_if_if.master bus
);

    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;

    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic [3:0]  req_strb;
    logic [31:0] req_lanes;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    // Decode of the incoming request; only consulted while IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        req_illegal = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = req_we;
            default:                req_illegal = 1'b1;
        endcase
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        req_strb  = 4'b1111;
        req_lanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                req_strb  = 4'b0001 << req_addr[1:0];
                req_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_strb  = 4'b0011 << req_addr[1:0];
                req_lanes = {2{req_wdata[15:0]}};
            end
            default: begin
                req_strb  = 4'b1111;
                req_lanes = req_wdata;
            end
        endcase
    end

    // Lane extraction and extension of the returned read word.
    always_comb begin
        lane_b   = bus.bus_rdata[{off_q, 3'b000} +: 8];
        lane_h   = bus.bus_rdata[{off_q[1], 4'b0000} +: 16];
        load_ext = '0;
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b010:  load_ext = bus.bus_rdata;
            3'b100:  load_ext = {24'b0, lane_b};
            3'b101:  load_ext = {16'b0, lane_h};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        off_d         = off_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        bus_valid_d   = 1'b0;
        bus_we_d      = 1'b0;
        bus_addr_d    = '0;
        bus_wstrb_d   = '0;
        bus_wdata_d   = '0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        fault_d       = 1'b0;
        fault_cause_d = CAUSE_NONE;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal) begin
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_ILLEGAL;
                    end else if (req_misaligned) begin
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        off_d       = req_addr[1:0];
                        we_d        = req_we;
                        funct3_d    = req_funct3;
                        bus_valid_d = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_wstrb_d = req_we ? req_strb : 4'b0000;
                        bus_wdata_d = req_we ? req_lanes : 32'b0;
                    end
                end
            end

            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.bus_ready && we_q) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    fault_d       = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                end else if (bus.bus_ready) begin
                    state_d = WAIT_R;
                end else begin
                    bus_valid_d = 1'b1;
                    bus_we_d    = bus_we_q;
                    bus_addr_d  = bus_addr_q;
                    bus_wstrb_d = bus_wstrb_q;
                    bus_wdata_d = bus_wdata_q;
                end
            end

            WAIT_R: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.bus_rvalid) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    fault_d       = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            off_q         <= '0;
            we_q          <= 1'b0;
            funct3_q      <= '0;
            bus_valid_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wstrb_q   <= '0;
            bus_wdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            off_q         <= off_d;
            we_q          <= we_d;
            funct3_q      <= funct3_d;
            bus_valid_q   <= bus_valid_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wstrb_q   <= bus_wstrb_d;
            bus_wdata_q   <= bus_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    // Stall must rise in the request cycle itself, so it is the one combinational output;
    // gating with rst keeps it at its reset value while reset is held.
    assign stall = !rst && ((state_q == IDLE && req_valid && !req_illegal && !req_misaligned) ||
                            state_q == REQ || state_q == WAIT_R);

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign fault         = fault_q;
    assign fault_cause   = fault_cause_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wstrb = bus_wstrb_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: stores, loads, faults, delayed handshakes, timeout and
// mid-transaction reset, with expected values worked out by hand.
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid2;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall, stall2;
    logic        rsp_valid, rsp_valid2;
    logic [31:0] rsp_rdata, rsp_rdata2;
    logic        fault, fault2;
    logic [1:0]  fault_cause, fault_cause2;

    int n_total = 0;
    int n_bad   = 0;

    lsu_bus_if_if bi();
    lsu_bus_if_if bi2();

    always #5 clk = ~clk;

    lsu_bus_if #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .fault       (fault),
        .fault_cause (fault_cause),
        .bus         (bi.master)
    );

    // Second instance with a short timeout; shares the request fields but has its own valid.
    lsu_bus_if #(.TIMEOUT(4)) dut_to (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid2),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall2),
        .rsp_valid   (rsp_valid2),
        .rsp_rdata   (rsp_rdata2),
        .fault       (fault2),
        .fault_cause (fault_cause2),
        .bus         (bi2.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_stall"},     stall,        0);
        check({tag, "_rsp_valid"}, rsp_valid,    0);
        check({tag, "_rsp_rdata"}, rsp_rdata,    0);
        check({tag, "_fault"},     fault,        0);
        check({tag, "_cause"},     fault_cause,  0);
        check({tag, "_bvalid"},    bi.bus_valid, 0);
        check({tag, "_bwe"},       bi.bus_we,    0);
        check({tag, "_baddr"},     bi.bus_addr,  0);
        check({tag, "_bstrb"},     bi.bus_wstrb, 0);
        check({tag, "_bwdata"},    bi.bus_wdata, 0);
    endtask

    task automatic set_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
    endtask

    // Called and returns just after a rising edge.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        set_req(we, f3, addr, wdata);
        mid();
        check({tag, "_c0_stall"},  stall,        1);
        check({tag, "_c0_bvalid"}, bi.bus_valid, 0);
        tick();
        for (int i = 0; i <= rdy_dly; i++) begin
            bi.bus_ready = (i == rdy_dly);
            mid();
            check({tag, "_req_stall"},  stall,        1);
            check({tag, "_req_bvalid"}, bi.bus_valid, 1);
            check({tag, "_req_baddr"},  bi.bus_addr,  exp_addr);
            check({tag, "_req_bwe"},    bi.bus_we,    {31'b0, we});
            check({tag, "_req_bstrb"},  bi.bus_wstrb, {28'b0, exp_strb});
            if (we) check({tag, "_req_bwdata"}, bi.bus_wdata, exp_wdata);
            tick();
        end
        bi.bus_ready = 1'b0;
        if (!we) begin
            for (int i = 0; i <= rv_dly; i++) begin
                bi.bus_rvalid = (i == rv_dly);
                bi.bus_rdata  = (i == rv_dly) ? rdata : 32'h5A5A_5A5A;
                mid();
                check({tag, "_wr_stall"},  stall,        1);
                check({tag, "_wr_bvalid"}, bi.bus_valid, 0);
                check({tag, "_wr_rsp"},    rsp_valid,    0);
                tick();
            end
            bi.bus_rvalid = 1'b0;
        end
        mid();
        check({tag, "_done_rsp"},   rsp_valid, 1);
        check({tag, "_done_stall"}, stall,     0);
        check({tag, "_done_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_done_fault"}, fault,     0);
        tick();
        req_valid = 1'b0;
        mid();
        check({tag, "_after_rsp"},   rsp_valid, 0);
        check({tag, "_after_stall"}, stall,     0);
        tick();
    endtask

    task automatic bad_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] exp_cause);
        set_req(we, f3, addr, 32'h1111_2222);
        mid();
        check({tag, "_stall"},  stall,        0);
        check({tag, "_bvalid"}, bi.bus_valid, 0);
        tick();
        req_valid = 1'b0;
        mid();
        check({tag, "_fault"},    fault,        1);
        check({tag, "_cause"},    fault_cause,  {30'b0, exp_cause});
        check({tag, "_bvalid2"},  bi.bus_valid, 0);
        check({tag, "_stall2"},   stall,        0);
        tick();
        mid();
        check({tag, "_fault_end"}, fault,       0);
        check({tag, "_cause_end"}, fault_cause, 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid2 = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        bi.bus_ready = 1'b0; bi.bus_rvalid = 1'b0; bi.bus_rdata = '0;
        bi2.bus_ready = 1'b1; bi2.bus_rvalid = 1'b0; bi2.bus_rdata = 32'h7777_7777;
        tick();
        tick();
        mid();
        check_idle("reset");
        tick();
        rst = 1'b0;
        tick();

        // Stores
        access("sw", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0,
               32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        access("sb", 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0, 0,
               32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        access("sh", 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0, 1, 0,
               32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0);

        // Loads at first opportunity
        access("lb", 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_80FF, 0, 0,
               32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_FF80);
        access("lbu", 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_80FF, 0, 0,
               32'h0000_0100, 4'b0000, 32'h0, 32'h0000_0080);
        access("lh", 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_0000, 0, 0,
               32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_8001);
        access("lhu", 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 0, 0,
               32'h0000_0100, 4'b0000, 32'h0, 32'h0000_8001);

        // Delayed ready and delayed read return
        access("lw_slow", 1'b0, 3'b010, 32'h0000_010C, 32'h0, 32'hCAFE_F00D, 3, 2,
               32'h0000_010C, 4'b0000, 32'h0, 32'hCAFE_F00D);

        // Rejected requests
        bad_req("lw_mis",   1'b0, 3'b010, 32'h0000_0102, 2'b01);
        bad_req("ld_f011",  1'b0, 3'b011, 32'h0000_0100, 2'b10);
        bad_req("st_f100",  1'b1, 3'b100, 32'h0000_0100, 2'b10);
        bad_req("sh_mis",   1'b1, 3'b001, 32'h0000_0201, 2'b01);
        bad_req("ill_prio", 1'b0, 3'b011, 32'h0000_0003, 2'b10);

        // Timeout on the short-timeout instance: bus accepts, read data never returns
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300; req_wdata = '0;
        req_valid2 = 1'b1;
        mid();
        check("to_c0_stall", stall2, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            mid();
            check("to_wait_stall", stall2, 1);
            check("to_wait_fault", fault2, 0);
        end
        tick();
        mid();
        check("to_done_fault",  fault2,        1);
        check("to_done_cause",  fault_cause2,  2'b11);
        check("to_done_rdata",  rsp_rdata2,    0);
        check("to_done_stall",  stall2,        0);
        check("to_done_rsp",    rsp_valid2,    1);
        check("to_done_bvalid", bi2.bus_valid, 0);
        tick();
        req_valid2 = 1'b0;
        mid();
        check("to_after_fault", fault2, 0);
        check("to_after_stall", stall2, 0);
        tick();

        // Reset while waiting for read data, then a stray read strobe
        set_req(1'b0, 3'b010, 32'h0000_0104, 32'h0);
        tick();
        bi.bus_ready = 1'b1;
        tick();
        bi.bus_ready = 1'b0;
        mid();
        check("rst_wait_stall", stall, 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_mid");
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        bi.bus_rvalid = 1'b1;
        bi.bus_rdata  = 32'h1234_5678;
        mid();
        check("stray_rsp", rsp_valid, 0);
        tick();
        bi.bus_rvalid = 1'b0;
        mid();
        check("stray_rsp2",   rsp_valid, 0);
        check("stray_rdata",  rsp_rdata, 0);
        check("stray_stall",  stall,     0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
